pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Consumes the ID-stage load-use stall request and the EX-stage branch redirect of the 5-stage RISC-V core.
- Sequences the per-stage enable/flush strobes that the PC and the pipeline registers (IF/ID, ID/EX, EX/MEM) obey.
- Adds memory-wait freezing with a watchdog and cycle bookkeeping.
- Sits between the hazard detector / branch unit and the pipeline registers.

Parameters:
- WAIT_MAX, 16: data-memory busy cycles tolerated before entering HALT.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- lu_hazard  in  1  load-use stall request from ID; active-high, level
- br_taken  in  1  branch/jump resolved taken in EX, one-cycle pulse per branch
- dmem_busy  in  1  data memory not ready; level
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_flush  out  1  ID/EX loads a bubble (control bits zeroed)
- ex_mem_write  out  1  EX/MEM load enable
- halted  out  1  watchdog tripped
- stall_cycles  out  PERF_W  PERF_CNT_EN only
- flush_cycles  out  PERF_W  PERF_CNT_EN only

Behaviour:
- Outputs are combinational from state and inputs. State, wait counter and perf counters are registers.
- While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_write=0, halted=0.
- On the first cycle after reset: state=RUN, wait_cnt=0, counters=0.
- States: RUN, MEM_WAIT, HALT.
- RUN priority, highest first:
  - (1) dmem_busy=1: freeze, meaning all write enables 0 and no flushes. Next state MEM_WAIT, wait_cnt=1.
  - (2) br_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_write=1. A branch overrides a simultaneous lu_hazard, because the stalled instruction is squashed.
  - (3) lu_hazard=1: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1. This inserts exactly one bubble per cycle the request is held.
  - (4) otherwise: all write enables 1, flushes 0.
- MEM_WAIT:
  - Freeze outputs as in RUN case (1).
  - br_taken and lu_hazard are ignored; they are held stable upstream by the freeze.
  - dmem_busy=0: return to RUN, wait_cnt=0. The RUN rules apply from the next cycle; the release cycle itself still freezes.
  - dmem_busy=1 and wait_cnt==WAIT_MAX: enter HALT.
  - Otherwise: wait_cnt increments.
- HALT:
  - All enables 0, if_id_flush=0, id_ex_flush=0, halted=1.
  - Exits only on rst.
- Freeze latency:
  - dmem_busy asserted at cycle N freezes at cycle N, combinationally.
  - Deasserted at cycle M, the pipeline resumes at M+1.
- wait_cnt never wraps; it saturates at WAIT_MAX.
- Reset mid-wait or in HALT: the next cycle is RUN with counters cleared.

Optional Feature:
- PIPELINE_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_write=0 outside reset.
  - flush_cycles increments on every cycle with if_id_flush=1 or id_ex_flush=1 outside reset.
  - Both saturate at all-ones and clear on rst.
- Undefined: the ports are absent and no counter logic is built.

Decomposition:
- Shared core package holds:
  - state encoding constants: RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2
  - NOP instruction constant 32'h00000013, used by the IF/ID flush consumer
- One natural sub-module: sat_counter (width-parameterised saturating counter with clear and enable). It is reused for wait_cnt and both perf counters.

Test Plan:
- Reset 3 cycles, then idle: reset cycles show pc_write=0, if_id_flush=1, id_ex_flush=1; the first RUN cycle has all enables 1 and flushes 0.
- lu_hazard=1 for 1 cycle in RUN: that cycle pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1; the next cycle is normal.
- br_taken=1 and lu_hazard=1 in the same cycle: pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
- dmem_busy high for 5 cycles with lu_hazard=1 throughout: 6 freeze cycles (5 busy plus the release cycle), then the load-use bubble rule applies.
- dmem_busy held for WAIT_MAX+2 cycles (16+2=18): halted=1 at cycle 17 and all enables 0; rst then returns to RUN with halted=0.
- With PIPELINE_PERF_CNT_EN, run 2 load-use stalls and 1 branch, no mem waits: stall_cycles=2, flush_cycles=3.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding and
// the NOP instruction that the IF/ID flush consumer substitutes.
package pipeline_stall_ctrl_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  typedef enum logic [1:0] {
    StRun     = RUN,
    StMemWait = MEM_WAIT,
    StHalt    = HALT
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Width-parameterised up-counter that sticks at MAX; synchronous clear wins over enable.
module sat_counter #(
  parameter int unsigned     W   = 8,
  parameter logic [W-1:0]    MAX = '1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up until MAX, then hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush sequencer: turns load-use, branch-redirect and data-memory busy
// into PC / pipeline-register enables and flushes, with a memory-wait watchdog.
// Optional cycle counters are built when PIPELINE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5,
  parameter int unsigned PERF_W   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic lu_hazard,
  input  logic br_taken,
  input  logic dmem_busy,
  output logic pc_write,
  output logic if_id_write,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic ex_mem_write,
  output logic halted
`ifdef PIPELINE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_cycles
`endif
);

  localparam logic [CNT_W-1:0] WaitMax = CNT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic              cnt_clr, cnt_en;

  // Next-state and wait-counter control.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StRun: begin
        // wait_cnt is 0 in RUN, so one increment lands on 1.
        if (dmem_busy) begin
          state_d = StMemWait;
          cnt_en  = 1'b1;
        end
      end
      StMemWait: begin
        if (!dmem_busy) begin
          state_d = StRun;
          cnt_clr = 1'b1;
        end else if (wait_cnt == WaitMax) begin
          state_d = StHalt;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StHalt: ;
      default: state_d = StRun;
    endcase
  end

  // State register; only reset leaves HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .W   (CNT_W),
    .MAX (WaitMax)
  ) u_wait_cnt (
    .clk   (clk),
    .clr   (rst | cnt_clr),
    .en    (cnt_en),
    .count (wait_cnt)
  );

  // Strobes are combinational so a busy memory freezes the pipe in the same cycle.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (dmem_busy) begin
            // freeze: everything already at 0
          end else if (br_taken) begin
            // Branch squashes any stalled instruction, so it beats lu_hazard.
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
          end else if (lu_hazard) begin
            id_ex_flush  = 1'b1;
            ex_mem_write = 1'b1;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            ex_mem_write = 1'b1;
          end
        end
        StMemWait: ; // freeze, including the release cycle
        StHalt:    halted = 1'b1;
        default:   ;
      endcase
    end
  end

`ifdef PIPELINE_PERF_CNT_EN
  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (~pc_write),
    .count (stall_cycles)
  );

  sat_counter #(
    .W (PERF_W)
  ) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (if_id_flush | id_ex_flush),
    .count (flush_cycles)
  );
`endif

endmodule
